// File: rtl/studio2_pkg.sv
// Shared definitions for the Studio II keypad responder.
// Holds the keypad size, the set-2 scan codes for both hex keypads
// (index = key number) and a combinational scan-code lookup.
package studio2_pkg;

    localparam int KP_KEYS = 10;

    typedef logic [KP_KEYS-1:0] kp_bitmap_t;

    localparam logic [7:0] KP1_CODES [KP_KEYS] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };

    localparam logic [7:0] KP2_CODES [KP_KEYS] = '{
        8'h4D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44
    };

    // hit: code belongs to a keypad; pad: 0 = keypad 1, 1 = keypad 2
    typedef struct packed {
        logic       hit;
        logic       pad;
        logic [3:0] key;
    } kp_hit_t;

    // The two maps share no codes, so at most one branch matches.
    function automatic kp_hit_t kp_lookup(input logic [7:0] code);
        kp_hit_t r;
        r = '0;
        for (int i = 0; i < KP_KEYS; i++) begin
            if (code == KP1_CODES[i]) begin
                r.hit = 1'b1;
                r.pad = 1'b0;
                r.key = 4'(i);
            end
            if (code == KP2_CODES[i]) begin
                r.hit = 1'b1;
                r.pad = 1'b1;
                r.key = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/studio2_key_hold.sv
// One key: raw pressed bit plus a minimum-hold down-counter.
// Ports:
//   clk_sys, reset_n  clock, async active-low reset
//   flush             synchronous clear of raw bit and counter (wins)
//   make, brk         decoded make/break strobes for this key
//   held              raw OR counter not yet expired
module studio2_key_hold
    import studio2_pkg::*;
#(
    parameter int                HOLD_W   = 16,
    parameter logic [HOLD_W-1:0] HOLD_MIN = 16'd4096
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic flush,
    input  logic make,
    input  logic brk,
    output logic held
);

    logic              raw_q, raw_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        raw_d = raw_q;
        cnt_d = (cnt_q != '0) ? cnt_q - HOLD_W'(1) : '0;
        if (make) begin
            raw_d = 1'b1;
            cnt_d = HOLD_MIN;
        end
        if (brk) begin
            raw_d = 1'b0;
        end
        if (flush) begin
            raw_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            raw_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            raw_q <= raw_d;
            cnt_q <= cnt_d;
        end
    end

    assign held = raw_q | (cnt_q != '0);

endmodule

// File: rtl/studio2_keypad_responder.sv
// CPU-facing responder for the two Studio II hex keypads.
// PS/2 make/break events update 20 per-key hold cells; the CPU picks a key
// number via OUT on SEL_PORT and reads it back on EF3 (keypad 1) / EF4
// (keypad 2), active-low.
// Ports:
//   clk_sys, reset_n  clock, async active-low reset
//   ps2_key           [10] toggle, [9] pressed, [8] extended, [7:0] code
//   flush             synchronous release-all
//   io_n/io_out/io_dout  CPU OUT interface
//   ef_n              [3]=EF4, [2]=EF3, [1:0]=1
//   key_sel           select latch
//   held1, held2      per-keypad held bitmaps
module studio2_keypad_responder
    import studio2_pkg::*;
#(
    parameter logic [2:0]        SEL_PORT = 3'd2,
    parameter int                HOLD_W   = 16,
    parameter logic [HOLD_W-1:0] HOLD_MIN = 16'd4096
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        flush,
    input  logic [2:0]  io_n,
    input  logic        io_out,
    input  logic [7:0]  io_dout,
    output logic [3:0]  ef_n,
    output logic [3:0]  key_sel,
    output kp_bitmap_t  held1,
    output kp_bitmap_t  held2
);

    logic       tog_q, tog_d;
    logic       armed_q, armed_d;
    logic       sel_hit_q, sel_hit_d;
    logic [3:0] key_sel_q, key_sel_d;
    logic       ef3_n_q, ef3_n_d;
    logic       ef4_n_q, ef4_n_d;

    logic       ps2_ev;
    kp_hit_t    lk;
    kp_bitmap_t make1, brk1, make2, brk2;
    logic       unused_dout;

    assign unused_dout = ^io_dout[7:4];

    // armed_q keeps the first sampled toggle level from looking like an event.
    assign ps2_ev = armed_q && (ps2_key[10] != tog_q) && !ps2_key[8];
    assign lk     = kp_lookup(ps2_key[7:0]);

    always_comb begin
        make1 = '0;
        brk1  = '0;
        make2 = '0;
        brk2  = '0;
        if (ps2_ev && lk.hit) begin
            if (!lk.pad) begin
                make1[lk.key] = ps2_key[9];
                brk1[lk.key]  = !ps2_key[9];
            end else begin
                make2[lk.key] = ps2_key[9];
                brk2[lk.key]  = !ps2_key[9];
            end
        end
    end

    for (genvar k = 0; k < KP_KEYS; k++) begin : g_keys
        studio2_key_hold #(.HOLD_W(HOLD_W), .HOLD_MIN(HOLD_MIN)) u_kp1 (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .flush   (flush),
            .make    (make1[k]),
            .brk     (brk1[k]),
            .held    (held1[k])
        );
        studio2_key_hold #(.HOLD_W(HOLD_W), .HOLD_MIN(HOLD_MIN)) u_kp2 (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .flush   (flush),
            .make    (make2[k]),
            .brk     (brk2[k]),
            .held    (held2[k])
        );
    end

    always_comb begin
        tog_d     = ps2_key[10];
        armed_d   = 1'b1;
        sel_hit_d = io_out && (io_n == SEL_PORT);
        key_sel_d = key_sel_q;
        // Capture only on the rising edge of the qualified strobe.
        if (sel_hit_d && !sel_hit_q) begin
            key_sel_d = io_dout[3:0];
        end
        ef3_n_d = !((key_sel_q <= 4'd9) && held1[key_sel_q]);
        ef4_n_d = !((key_sel_q <= 4'd9) && held2[key_sel_q]);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q     <= 1'b0;
            armed_q   <= 1'b0;
            sel_hit_q <= 1'b0;
            key_sel_q <= 4'hF;
            ef3_n_q   <= 1'b1;
            ef4_n_q   <= 1'b1;
        end else begin
            tog_q     <= tog_d;
            armed_q   <= armed_d;
            sel_hit_q <= sel_hit_d;
            key_sel_q <= key_sel_d;
            ef3_n_q   <= ef3_n_d;
            ef4_n_q   <= ef4_n_d;
        end
    end

    assign ef_n    = {ef4_n_q, ef3_n_q, 2'b11};
    assign key_sel = key_sel_q;

endmodule

// File: tb/tb_studio2_keypad_responder.sv
module tb_studio2_keypad_responder;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        flush;
    logic [2:0]  io_n;
    logic        io_out;
    logic [7:0]  io_dout;
    logic [3:0]  ef_n;
    logic [3:0]  key_sel;
    logic [9:0]  held1;
    logic [9:0]  held2;

    int n_total = 0;
    int n_pass  = 0;
    logic tgl;

    studio2_keypad_responder dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ps2_key (ps2_key),
        .flush   (flush),
        .io_n    (io_n),
        .io_out  (io_out),
        .io_dout (io_dout),
        .ef_n    (ef_n),
        .key_sel (key_sel),
        .held1   (held1),
        .held2   (held2)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       pressed;
        logic [9:0] exp_h1;
        logic [9:0] exp_h2;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic set_key(input logic pressed, input logic ext, input logic [7:0] code);
        tgl = ~tgl;
        ps2_key = {tgl, pressed, ext, code};
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        set_key(pressed, ext, code);
        tick();
    endtask

    task automatic cpu_out(input logic [7:0] d);
        io_n = 3'd2; io_out = 1'b1; io_dout = d;
        tick();
        io_out = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h45, 1'b0, 1'b1, 10'b00_0000_0001, 10'b00_0000_0000};
        vecs[1] = '{8'h4D, 1'b0, 1'b1, 10'b00_0000_0001, 10'b00_0000_0001};
        vecs[2] = '{8'h5A, 1'b0, 1'b1, 10'b00_0000_0001, 10'b00_0000_0001};
        vecs[3] = '{8'h1E, 1'b1, 1'b1, 10'b00_0000_0001, 10'b00_0000_0001};
        vecs[4] = '{8'h44, 1'b0, 1'b1, 10'b00_0000_0001, 10'b10_0000_0001};
        vecs[5] = '{8'h45, 1'b0, 1'b0, 10'b00_0000_0001, 10'b10_0000_0001};
        vecs[6] = '{8'h46, 1'b0, 1'b1, 10'b10_0000_0001, 10'b10_0000_0001};

        reset_n = 1'b0; flush = 1'b0; io_n = 3'd0; io_out = 1'b0; io_dout = 8'h00;
        tgl = 1'b1;
        ps2_key = 11'h400;
        tick(); tick();
        chk("rst_ef", 32'(ef_n), 32'hF);
        chk("rst_sel", 32'(key_sel), 32'hF);
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("rel_held1", 32'(held1), 32'h0);
        chk("rel_held2", 32'(held2), 32'h0);
        chk("rel_ef", 32'(ef_n), 32'hF);
        chk("rel_sel", 32'(key_sel), 32'hF);

        // keypad 1 key 1 then select 1
        send_key(1'b1, 1'b0, 8'h16);
        chk("mk16_held1", 32'(held1), 32'h002);
        cpu_out(8'h01);
        chk("sel1", 32'(key_sel), 32'h1);
        chk("sel1_ef_lat", 32'(ef_n), 32'hF);
        tick();
        chk("sel1_ef", 32'(ef_n), 32'hB);

        do_flush();
        chk("flush_held1", 32'(held1), 32'h0);
        chk("flush_keepsel", 32'(key_sel), 32'h1);
        tick();
        chk("flush_ef", 32'(ef_n), 32'hF);

        // table-driven event sequence
        for (int i = 0; i < 7; i++) begin
            send_key(vecs[i].pressed, vecs[i].ext, vecs[i].code);
            chk($sformatf("vec%0d_h1", i), 32'(held1), 32'(vecs[i].exp_h1));
            chk($sformatf("vec%0d_h2", i), 32'(held2), 32'(vecs[i].exp_h2));
        end
        do_flush();

        // minimum hold after early break
        cpu_out(8'h02);
        send_key(1'b1, 1'b0, 8'h1D);          // make edge, k = 0
        repeat (10) tick();                   // k = 10
        send_key(1'b0, 1'b0, 8'h1D);          // k = 11
        chk("hold_raw_gone", 32'(held2), 32'h004);
        repeat (4095 - 11) tick();            // k = 4095
        chk("hold_last_h2", 32'(held2), 32'h004);
        chk("hold_last_ef", 32'(ef_n), 32'h7);
        tick();                               // k = 4096
        chk("hold_exp_h2", 32'(held2), 32'h0);
        chk("hold_exp_ef", 32'(ef_n), 32'h7);
        tick();
        chk("hold_exp_ef1", 32'(ef_n), 32'hF);

        // long strobe with changing data
        io_n = 3'd2; io_out = 1'b1; io_dout = 8'h05;
        tick(); tick();
        io_dout = 8'h07;
        tick(); tick(); tick();
        chk("strobe_sel", 32'(key_sel), 32'h5);
        io_out = 1'b0;
        tick();
        chk("strobe_sel_after", 32'(key_sel), 32'h5);
        io_n = 3'd3; io_out = 1'b1; io_dout = 8'h09;
        tick();
        io_out = 1'b0;
        tick();
        chk("wrong_port", 32'(key_sel), 32'h5);

        // both keypads on key 0, select captured in the same cycle as an event
        send_key(1'b1, 1'b0, 8'h45);
        set_key(1'b1, 1'b0, 8'h4D);
        io_n = 3'd2; io_out = 1'b1; io_dout = 8'h00;
        tick();
        io_out = 1'b0;
        chk("both_sel0", 32'(key_sel), 32'h0);
        tick();
        chk("both_ef", 32'(ef_n), 32'h3);
        cpu_out(8'h0A);
        tick();
        chk("sel10_ef", 32'(ef_n), 32'hF);
        do_flush();

        // flush coincident with make
        flush = 1'b1;
        set_key(1'b1, 1'b0, 8'h26);
        tick();
        flush = 1'b0;
        chk("flush_mk_h1", 32'(held1), 32'h0);
        tick(); tick(); tick();
        chk("flush_mk_h1_later", 32'(held1), 32'h0);

        // reset mid-hold
        send_key(1'b1, 1'b0, 8'h16);
        cpu_out(8'h01);
        tick();
        chk("pre_rst_ef", 32'(ef_n), 32'hB);
        #2;
        reset_n = 1'b0;
        tgl = 1'b1;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h16};
        #1;
        chk("async_ef", 32'(ef_n), 32'hF);
        chk("async_h1", 32'(held1), 32'h0);
        chk("async_sel", 32'(key_sel), 32'hF);
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("no_spurious_h1", 32'(held1), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/studio2_keypad_responder.md
Name: studio2_keypad_responder

Overview:
- CPU-facing responder for the two Studio II hex keypads.
- The CPU selects a key number with an OUT instruction on port N=2. The block answers on EF3 (keypad 1) and EF4 (keypad 2), active-low, when the selected key is held.
- Key state comes from the PS/2 key event bus. Sits between the PS/2 input and the cdp1802 EF inputs, replacing the ad-hoc keypad logic in the top level.

Parameters:
- SEL_PORT, 3'd2: io_n value that addresses the key-select latch.
- HOLD_MIN, 16'd4096: minimum clk_sys cycles a key reads as pressed after its make event, so fast taps are seen by polling software.
- HOLD_W, 16: width of the hold counters.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] set-2 scan code
- flush  in  1  synchronous release-all (e.g. during ioctl_download)
- io_n  in  3  CPU N lines
- io_out  in  1  CPU OUT strobe (may be high for several cycles)
- io_dout  in  8  CPU data bus during OUT
- ef_n  out  4  [3]=EF4, [2]=EF3, [1:0] tied 1; active-low
- key_sel  out  4  current select latch
- held1  out  10  keypad-1 held bitmap (bit k = key k)
- held2  out  10  keypad-2 held bitmap

Behaviour:
- Reset (async, reset_n=0) values:
  - held1 = held2 = 0
  - all hold counters = 0
  - key_sel = 4'hF
  - ef_n = 4'b1111
  - toggle history = ps2_key[10], sampled at the first clock after reset release; no spurious event.
- PS/2 event detection:
  - An event fires on the cycle ps2_key[10] differs from its registered copy. One event per toggle.
  - Events with ps2_key[8]=1 (extended) are ignored.
- Key map, keypad 1 (keys 0..9): 45,16,1E,26,25,2E,36,3D,3E,46.
- Key map, keypad 2 (keys 0..9): 4D,15,1D,24,2D,2C,35,3C,43,44.
- Unmapped codes are ignored and do not disturb existing held state. This differs from the old top-level logic, which cleared the keypads.
- Make event (pressed=1), key k:
  - set raw bit k
  - load that keypad's hold counter for k with HOLD_MIN
- Break event (pressed=0): clear raw bit k.
- held[k] = raw[k] OR (hold counter[k] != 0). Counters decrement by 1 per cycle and saturate at 0. 20 counters total.
- Repeated make on a held key reloads the counter; no other effect.
- Select latch:
  - Capture io_dout[3:0] into key_sel on the rising edge of (io_out AND io_n==SEL_PORT). Single capture per strobe regardless of strobe length.
  - io_dout[7:4] ignored.
- EF generation, registered, 1-cycle latency from key_sel or held change:
  - ef_n[2] = ~(key_sel<=9 AND held1[key_sel])
  - ef_n[3] = ~(key_sel<=9 AND held2[key_sel])
  - key_sel 10..15 gives both 1.
- Both keypads holding the same key number: EF3 and EF4 are both asserted.
- Simultaneous events:
  - PS/2 event and select capture in the same cycle: both take effect. EF reflects both one cycle later.
  - flush coincident with a make: flush wins, so raw, held and counters are all cleared.
- flush: clears raw bits and counters in 1 cycle; key_sel is retained.
- Reset mid-hold: counters and held state clear immediately (async). ef_n returns to 1111 asynchronously.

Decomposition:
- Shared package studio2_pkg:
  - KP_KEYS=10
  - scan-code constant arrays KP1_CODES and KP2_CODES
  - typedef kp_bitmap_t (logic [9:0])
- One sub-module, studio2_key_hold: one key's raw bit plus its hold counter, parameterised by HOLD_MIN/HOLD_W. Instantiated 20 times via generate.
- Scan-code lookup is a combinational function in the package.

Test Plan:
- Reset release with ps2_key[10]=1 held → no event; ef_n=4'b1111, key_sel=4'hF, held1=held2=0.
- Make 16 (kp1 key 1), then OUT port 2 data 8'h01 → key_sel=1, ef_n[2]=0 one cycle after capture, ef_n[3]=1.
- Make 1D then break 1D 10 cycles later, HOLD_MIN=4096, key_sel=2 → ef_n[3]=0 until cycle 4096 after make, then 1.
- OUT strobe held 5 cycles with data changing 05→07 mid-strobe → key_sel=5 only.
- Make 45 and 4D, key_sel=0 → ef_n=4'b0011; OUT 8'h0A → ef_n=4'b1111.
- Extended event (bit8=1, code 16), unmapped code 5A make, and flush coinciding with a make → held unchanged, unchanged, and all-zero respectively.
